// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data-memory initiator: RV32 load/store
// funct3 codes, fault codes and the controller state encoding.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side and memory-side signals of the MEM-stage data access path.
// master = the controller, slave = pipeline plus memory responder.
interface mem_access_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  ctrl_read;
    logic                  ctrl_write;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] alu_address;
    logic [31:0]           store_data;
    logic [31:0]           load_data;
    logic                  stall;
    logic [1:0]            fault;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_writedata;
    logic [31:0]           mem_readdata;
    logic                  mem_busywait;

    // Handshake: the responder latches a request on the first rising edge with
    // mem_read or mem_write high (held for exactly one cycle); the transfer
    // completes on the first later edge with mem_busywait low, where
    // mem_readdata is sampled. The pipeline holds ctrl_* stable while stall=1.
    modport master (
        input  ctrl_read, ctrl_write, funct3, alu_address, store_data,
        input  mem_readdata, mem_busywait,
        output load_data, stall, fault,
        output mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        output ctrl_read, ctrl_write, funct3, alu_address, store_data,
        output mem_readdata, mem_busywait,
        input  load_data, stall, fault,
        input  mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/byte_lane_align.sv
// Combinational lane logic: selects and extends load bytes/halves from a
// memory word, and merges sub-word store data into a read word.
module byte_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_store_data,
    output logic [31:0] o_load_value,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_LB:   o_load_value = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_load_value = {24'h000000, w_byte};
            F3_LH:   o_load_value = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_load_value = {16'h0000, w_half};
            default: o_load_value = i_rdata;
        endcase
    end

    // Halfword stores only reach here aligned, so lane[1] picks the half.
    always_comb begin
        o_merged_word = i_rdata;
        case (i_funct3)
            F3_SB: o_merged_word[{i_lane, 3'b000} +: 8] = i_store_data[7:0];
            F3_SH: begin
                if (i_lane[1]) o_merged_word[31:16] = i_store_data;
                else           o_merged_word[15:0]  = i_store_data;
            end
            default: o_merged_word = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage data-memory initiator: turns pipeline load/store requests into
// word-aligned read/write transactions, with read-modify-write for SB/SH.
module mem_access_controller
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int WAIT_TIMEOUT = 255,
    parameter int TO_CNT_W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    mem_access_if.master bus,
    output state_t       o_state
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(WAIT_TIMEOUT - 1);

    state_t                r_state;
    logic [1:0]            r_lane;
    logic [2:0]            r_funct3;
    logic                  r_is_store;
    logic [15:0]           r_store_lo;
    logic [TO_CNT_W-1:0]   r_to_cnt;
    logic [31:0]           r_load_data;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [31:0]           r_mem_writedata;
    logic [1:0]            r_fault;

    logic        w_req;
    logic        w_f3_valid;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_is_sw;
    logic [31:0] w_load_value;
    logic [31:0] w_merged_word;

    assign w_req        = bus.ctrl_read | bus.ctrl_write;
    assign w_f3_valid   = bus.ctrl_write ? (bus.funct3 inside {F3_SB, F3_SH, F3_SW})
                                         : (bus.funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    assign w_illegal    = (bus.ctrl_read & bus.ctrl_write) | ~w_f3_valid;
    assign w_misaligned = ((bus.funct3[1:0] == 2'b01) & bus.alu_address[0]) |
                          ((bus.funct3[1:0] == 2'b10) & (bus.alu_address[1:0] != 2'b00));
    assign w_is_sw      = bus.ctrl_write & (bus.funct3 == F3_SW);

    byte_lane_align u_align (
        .i_funct3      (r_funct3),
        .i_lane        (r_lane),
        .i_rdata       (bus.mem_readdata),
        .i_store_data  (r_store_lo),
        .o_load_value  (w_load_value),
        .o_merged_word (w_merged_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_lane          <= '0;
            r_funct3        <= '0;
            r_is_store      <= 1'b0;
            r_store_lo      <= '0;
            r_to_cnt        <= '0;
            r_load_data     <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_fault         <= FAULT_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_lane     <= bus.alu_address[1:0];
                        r_funct3   <= bus.funct3;
                        r_is_store <= bus.ctrl_write;
                        r_store_lo <= bus.store_data[15:0];
                        if (w_illegal) begin
                            r_fault <= FAULT_ILLEGAL;
                            r_state <= S_DONE;
                        end else if (w_misaligned) begin
                            r_fault <= FAULT_MISALIGN;
                            r_state <= S_DONE;
                        end else begin
                            r_mem_address <= {bus.alu_address[ADDR_WIDTH-1:2], 2'b00};
                            if (w_is_sw) begin
                                r_mem_write     <= 1'b1;
                                r_mem_writedata <= bus.store_data;
                                r_state         <= S_WR_REQ;
                            end else begin
                                r_mem_read <= 1'b1;
                                r_state    <= S_RD_REQ;
                            end
                        end
                    end
                end
                S_RD_REQ: begin
                    r_mem_read <= 1'b0;
                    r_to_cnt   <= '0;
                    r_state    <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (!bus.mem_busywait) begin
                        if (r_is_store) begin
                            r_mem_write     <= 1'b1;
                            r_mem_writedata <= w_merged_word;
                            r_state         <= S_WR_REQ;
                        end else begin
                            r_load_data <= w_load_value;
                            r_state     <= S_DONE;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_fault <= FAULT_TIMEOUT;
                        r_state <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
                    end
                end
                S_WR_REQ: begin
                    r_mem_write <= 1'b0;
                    r_to_cnt    <= '0;
                    r_state     <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (!bus.mem_busywait) begin
                        r_state <= S_DONE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_fault <= FAULT_TIMEOUT;
                        r_state <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_fault         <= FAULT_NONE;
                    r_mem_address   <= '0;
                    r_mem_writedata <= '0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset gates stall so every output reads 0 while reset is held.
    assign bus.stall         = w_req & (r_state != S_DONE) & ~reset;
    assign bus.load_data     = r_load_data;
    assign bus.fault         = r_fault;
    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.mem_address   = r_mem_address;
    assign bus.mem_writedata = r_mem_writedata;
    assign o_state           = r_state;

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
Initiator side of the data-memory read/write/busywait protocol, sitting in the MEM stage of the RV32IM pipeline. Converts pipeline load/store controls (funct3-sized byte, halfword or word) into word-aligned memory transactions. Performs read-modify-write for sub-word stores and aligns and extends load data. Stalls the pipeline until each transaction completes.

Parameters:
ADDR_WIDTH, 32, byte address width from ALU and to memory
WAIT_TIMEOUT, 255, max cycles in a wait state before a timeout fault
TO_CNT_W, 8, width of the timeout counter (must hold WAIT_TIMEOUT)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ctrl_read  in  1  pipeline load request; held while stall=1
ctrl_write  in  1  pipeline store request; held while stall=1
funct3  in  3  access size/sign (RV32 load/store encoding)
alu_address  in  ADDR_WIDTH  byte address
store_data  in  32  rs2 value; low bytes used for SB/SH
load_data  out  32  aligned, extended load result
stall  out  1  freeze pipeline
fault  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal (read and write both set)
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_address  out  ADDR_WIDTH  word address, bits [1:0] always 00
mem_writedata  out  32  full word to write
mem_readdata  in  32  word returned by memory
mem_busywait  in  1  memory busy

Behaviour:
- Reset (async, active-high, asserted at any time including mid-transaction): state IDLE; all outputs 0 immediately; timeout counter 0; latched address/size/data cleared.
- Protocol: responder latches request at the first rising edge where mem_read/mem_write is high. Controller holds the request exactly one cycle (the REQ state), then drops it and waits. Completion is the first edge in a WAIT state with mem_busywait=0. mem_readdata is sampled at that edge. mem_read and mem_write are never high together.
- Outputs mem_read, mem_write, mem_address and mem_writedata are registered (decoded from state and latched regs).
- stall = (ctrl_read | ctrl_write) & (state != DONE). It is combinational, so it is high in the IDLE cycle the request appears.
- States:
  - IDLE: sample ctrl_read/ctrl_write, funct3 and address; latch them.
    - Both set -> DONE, fault=11.
    - Misaligned -> DONE, fault=01. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
    - Load or sub-word store -> RD_REQ. SW -> WR_REQ.
  - RD_REQ: mem_read=1 -> RD_WAIT.
  - RD_WAIT: on busywait=0:
    - load: capture the aligned word into load_data -> DONE.
    - sub-word store: merge store byte/half into the read word at lane addr[1:0] -> WR_REQ.
  - WR_REQ: mem_write=1, mem_writedata = merged word or store_data -> WR_WAIT.
  - WR_WAIT: on busywait=0 -> DONE.
  - DONE: stall=0 for one cycle; fault is valid this cycle only -> IDLE.
- Timeout: counter increments each cycle in RD_WAIT/WR_WAIT and resets on entry to either. On reaching WAIT_TIMEOUT -> DONE with fault=10; load_data is unchanged.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - Lanes are little-endian: byte n is at bits [8n+7:8n].
- load_data holds its last value until the next successful load completes; stores do not modify it.
- Unknown funct3 (011, 110, 111) is treated as illegal: fault=11, no memory access.
- Latency with a zero-wait responder, counted as stall cycles before DONE: load 3; SW 3; SB/SH 5.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
  - fault codes
  - state enumeration
- One combinational sub-module, byte_lane_align, handles load lane select/extension and store merge. The FSM, counter and registers stay in the top module.

Test Plan:
- Memory word 0x80FF7F01 at address 0x10. LB addr 0x12 -> load_data 0xFFFFFFFF. LBU 0x13 -> 0x00000080. LH 0x10 -> 0x00007F01. Each load shows 3 stall cycles.
- Word 0x11223344 at 0x20. SB 0x21 with store_data 0xAB -> RD_REQ then WR_REQ, memory ends 0x1122AB44, 5 stall cycles. SH 0x22 with 0xBEEF -> 0xBEEFAB44.
- LW at 0x06 and SH at 0x05 -> fault=01, no mem_read/mem_write pulse, DONE on the next cycle.
- mem_busywait held high for 300 cycles on a load -> fault=10 after 255 wait cycles, load_data unchanged, returns to IDLE.
- Assert reset in WR_WAIT of an SB -> mem_write/stall drop asynchronously, state IDLE. After release a new LW completes normally.
- ctrl_read=ctrl_write=1, and funct3=011 load -> fault=11, no memory request, single stall cycle.
